rivyera_tx_arbiter: RTL

- Shares the single RIVYERA API output register port (api_o_*) between NUM_REQ user requesters.
- Round-robin, packet-locked arbitration; the port stays with one requester until that requester marks its last word or hits a burst limit.
- Honours api_o_rfd_in flow control.
- Sits between user cores and the API output register port in the top-level user design.

---
 rtl/rivyera_txarb_pkg.sv | 34 +++
 rtl/rivyera_rr_pick.sv | 44 ++++
 rtl/rivyera_tx_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rivyera_txarb_pkg.sv
// -----------------------------------------------------------------------------
// rivyera_txarb_pkg
//   Shared definitions for the RIVYERA TX arbiter slice:
//   - API field widths and the write command code. These mirror the values in
//     the SciEngines API constants header so the arbiter and the API output
//     register port agree on field sizes.
//   - FSM state encoding (ARB = 1'b0, BUSY = 1'b1).
//   - Width helper for the per-grant burst counter.
//
// Optional feature macro used by the arbiter: RIVYERA_TXARB_FIXED_PRIO_EN
// -----------------------------------------------------------------------------
package rivyera_txarb_pkg;

    localparam int C_LENGTH_ADDR_SLOT = 4;
    localparam int C_LENGTH_ADDR_FPGA = 4;
    localparam int C_LENGTH_ADDR_REG  = 8;
    localparam int C_LENGTH_CMD       = 8;
    localparam int C_LENGTH_DATA      = 64;

    localparam logic [C_LENGTH_CMD-1:0] CMD_WR = 8'h01;

    typedef logic [C_LENGTH_ADDR_REG-1:0] reg_addr_t;

    typedef enum logic {
        ARB  = 1'b0,
        BUSY = 1'b1
    } txarb_state_t;

    // The counter must be able to hold the value MAX_BURST itself.
    function automatic int burst_cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/rivyera_rr_pick.sv
// -----------------------------------------------------------------------------
// rivyera_rr_pick
//   Combinational rotating picker: returns the first asserted bit of valid_in
//   at or after ptr_in, wrapping around. Tie ptr_in to zero for strict
//   lowest-index priority.
//
// Ports:
//   valid_in   [NUM_REQ-1:0]  request vector
//   ptr_in     [IDX_W-1:0]    search start index
//   onehot_out [NUM_REQ-1:0]  one-hot winner (0 when no request)
//   idx_out    [IDX_W-1:0]    winner index (0 when no request)
//   any_out                   at least one request present
// -----------------------------------------------------------------------------
module rivyera_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid_in,
    input  logic [IDX_W-1:0]   ptr_in,
    output logic [NUM_REQ-1:0] onehot_out,
    output logic [IDX_W-1:0]   idx_out,
    output logic               any_out
);

    int cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        onehot_out = '0;
        idx_out    = '0;
        any_out    = 1'b0;
        cand       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr_in) + off) % NUM_REQ;
            if (!any_out && valid_in[cand[IDX_W-1:0]]) begin
                any_out                        = 1'b1;
                onehot_out[cand[IDX_W-1:0]]    = 1'b1;
                idx_out                        = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rivyera_tx_arbiter.sv
// -----------------------------------------------------------------------------
// rivyera_tx_arbiter
//   Shares the RIVYERA API output register port between NUM_REQ requesters.
//   Packet-locked arbitration: once granted, a requester owns the port until
//   it presents a word with req_last_in set, or until MAX_BURST words have
//   been accepted. One ARB cycle separates consecutive grants.
//
//   Default build: round-robin, search starts one past the last owner.
//   RIVYERA_TXARB_FIXED_PRIO_EN defined: strict priority, lowest index wins;
//   MAX_BURST still bounds how long one requester holds the port.
//
// Ports:
//   api_clk_in / api_rst_n_in  clock, asynchronous active-low reset
//   req_valid_in/last_in       per-requester word valid / last word of packet
//   req_ready_out              per-requester word accepted this cycle
//   req_slot/fpga/reg/cmd/data packed per-requester fields, requester i at slice i
//   grant_out                  one-hot current owner, 0 when idle
//   api_o_clk_out              forwarded api_clk_in
//   api_o_rfd_in               API ready-for-data
//   api_o_*_out                registered API word fields
//   api_o_wr_en_out            registered write strobe, one clock after accept
// -----------------------------------------------------------------------------
module rivyera_tx_arbiter
    import rivyera_txarb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int SRC_REG_BASE = 0
) (
    input  logic                                     api_clk_in,
    input  logic                                     api_rst_n_in,

    input  logic [NUM_REQ-1:0]                       req_valid_in,
    input  logic [NUM_REQ-1:0]                       req_last_in,
    output logic [NUM_REQ-1:0]                       req_ready_out,
    input  logic [NUM_REQ*C_LENGTH_ADDR_SLOT-1:0]    req_slot_in,
    input  logic [NUM_REQ*C_LENGTH_ADDR_FPGA-1:0]    req_fpga_in,
    input  logic [NUM_REQ*C_LENGTH_ADDR_REG-1:0]     req_reg_in,
    input  logic [NUM_REQ*C_LENGTH_CMD-1:0]          req_cmd_in,
    input  logic [NUM_REQ*C_LENGTH_DATA-1:0]         req_data_in,
    output logic [NUM_REQ-1:0]                       grant_out,

    output logic                                     api_o_clk_out,
    input  logic                                     api_o_rfd_in,
    output logic [C_LENGTH_ADDR_SLOT-1:0]            api_o_tgt_slot_out,
    output logic [C_LENGTH_ADDR_FPGA-1:0]            api_o_tgt_fpga_out,
    output logic [C_LENGTH_ADDR_REG-1:0]             api_o_tgt_reg_out,
    output logic [C_LENGTH_CMD-1:0]                  api_o_tgt_cmd_out,
    output logic [C_LENGTH_ADDR_REG-1:0]             api_o_src_reg_out,
    output logic [C_LENGTH_CMD-1:0]                  api_o_src_cmd_out,
    output logic [C_LENGTH_DATA-1:0]                 api_o_data_out,
    output logic                                     api_o_wr_en_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = burst_cnt_width(MAX_BURST);

    txarb_state_t        state, state_nxt;
    logic [IDX_W-1:0]    gidx;
    logic [IDX_W-1:0]    ptr;
    logic [CNT_W-1:0]    cnt;

    logic [NUM_REQ-1:0]  pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;

    logic                accept;
    logic                rel;

    assign api_o_clk_out = api_clk_in;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    rivyera_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_in   (req_valid_in),
        .ptr_in     (ptr),
        .onehot_out (pick_onehot),
        .idx_out    (pick_idx),
        .any_out    (pick_any)
    );

    // ------------------------------------------------------------------
    // Accept / release
    // ------------------------------------------------------------------
    assign accept = (state == BUSY) && req_valid_in[gidx] && api_o_rfd_in;

    // The count compare uses the pre-increment value: this accept is the
    // MAX_BURST-th when cnt already holds MAX_BURST-1. A word that is both
    // last and the burst limit releases once, like any other release.
    assign rel = accept && (req_last_in[gidx] || (cnt == CNT_W'(MAX_BURST - 1)));

    // Only the owner can see ready, and only on a real accept.
    assign req_ready_out = accept ? grant_out : '0;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (pick_any) state_nxt = BUSY;
            BUSY:    if (rel)      state_nxt = ARB;
            default:               state_nxt = ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
        if (!api_rst_n_in) begin
            state     <= ARB;
            grant_out <= '0;
            gidx      <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB && pick_any) begin
                grant_out <= pick_onehot;
                gidx      <= pick_idx;
            end else if (rel) begin
                grant_out <= '0;
                cnt       <= '0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef RIVYERA_TXARB_FIXED_PRIO_EN
    // Strict priority: search always starts at requester 0.
    assign ptr = '0;
`else
    // Round-robin: after a release the search starts one past the owner.
    always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
        if (!api_rst_n_in) begin
            ptr <= '0;
        end else if (rel) begin
            ptr <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // API output register: fields load on accept and hold otherwise, so the
    // strobe trails the accept by exactly one clock.
    // ------------------------------------------------------------------
    always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
        if (!api_rst_n_in) begin
            api_o_tgt_slot_out <= '0;
            api_o_tgt_fpga_out <= '0;
            api_o_tgt_reg_out  <= '0;
            api_o_tgt_cmd_out  <= '0;
            api_o_src_reg_out  <= '0;
            api_o_src_cmd_out  <= CMD_WR;
            api_o_data_out     <= '0;
            api_o_wr_en_out    <= 1'b0;
        end else begin
            api_o_wr_en_out <= accept;
            if (accept) begin
                api_o_tgt_slot_out <= req_slot_in[gidx*C_LENGTH_ADDR_SLOT +: C_LENGTH_ADDR_SLOT];
                api_o_tgt_fpga_out <= req_fpga_in[gidx*C_LENGTH_ADDR_FPGA +: C_LENGTH_ADDR_FPGA];
                api_o_tgt_reg_out  <= req_reg_in[gidx*C_LENGTH_ADDR_REG +: C_LENGTH_ADDR_REG];
                api_o_tgt_cmd_out  <= req_cmd_in[gidx*C_LENGTH_CMD +: C_LENGTH_CMD];
                api_o_src_reg_out  <= reg_addr_t'(SRC_REG_BASE) + reg_addr_t'(gidx);
                api_o_src_cmd_out  <= CMD_WR;
                api_o_data_out     <= req_data_in[gidx*C_LENGTH_DATA +: C_LENGTH_DATA];
            end
        end
    end

endmodule
